// File: rtl/invsqrt_pkg.sv
// Shared constants, FSM state encoding and FP-unit opcode for the inverse-square-root sequencer.
package invsqrt_pkg;

  localparam logic [31:0] MAGIC_DEF     = 32'h5f3759df;
  localparam logic [31:0] FP_HALF       = 32'h3F000000;
  localparam logic [31:0] FP_THREEHALFS = 32'h3FC00000;
  localparam logic [31:0] FP_PINF       = 32'h7F800000;
  localparam logic [31:0] FP_QNAN       = 32'h7FC00000;
  localparam logic [31:0] FP_ZERO       = 32'h00000000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HALF = 3'd1,
    SQ   = 3'd2,
    MULX = 3'd3,
    SUB  = 3'd4,
    UPD  = 3'd5,
    DONE = 3'd6
  } state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_SUB = 1'b1
  } op_sel_t;

  function automatic logic is_op_state(state_t s);
    case (s)
      HALF, SQ, MULX, SUB, UPD: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/invsqrt_seed.sv
// Combinational magic-constant seed MAGIC - (x >> 1).
// With INVSQRT_SPECIAL_EN defined it also flags operands that bypass refinement and supplies their result.
module invsqrt_seed
  import invsqrt_pkg::*;
#(
  parameter logic [31:0] MAGIC = MAGIC_DEF
) (
  input  logic [31:0] x_i,
  output logic [31:0] seed_o,
  output logic        special_o,
  output logic [31:0] special_val_o
);

  assign seed_o = MAGIC - {1'b0, x_i[31:1]};

`ifdef INVSQRT_SPECIAL_EN
  // zero/denormal is tested first, so a negative denormal also maps to +inf
  always_comb begin
    special_o     = 1'b1;
    special_val_o = FP_QNAN;
    if (x_i[30:23] == 8'h00) begin
      special_val_o = FP_PINF;
    end else if (x_i[30:23] == 8'hFF) begin
      if ((x_i[22:0] == 23'd0) && !x_i[31]) begin
        special_val_o = FP_ZERO;
      end else begin
        special_val_o = FP_QNAN;
      end
    end else if (x_i[31]) begin
      special_val_o = FP_QNAN;
    end else begin
      special_o     = 1'b0;
      special_val_o = FP_ZERO;
    end
  end
`else
  assign special_o     = 1'b0;
  assign special_val_o = FP_ZERO;
`endif

endmodule

// File: rtl/invsqrt_nr_ctrl.sv
// Fast inverse square root: magic seed, then NR_ITER Newton-Raphson steps issued one at a time to a shared FP unit.
// Optional macro INVSQRT_SPECIAL_EN: zero/denormal/negative/inf/NaN operands skip the FP unit entirely.
module invsqrt_nr_ctrl
  import invsqrt_pkg::*;
#(
  parameter int          NR_ITER = 1,
  parameter logic [31:0] MAGIC   = MAGIC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        op_valid,
  output logic        op_sel,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic        op_done,
  input  logic [31:0] op_result
);

  localparam logic [1:0] NR_LIM = 2'(NR_ITER);

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d, x2_q, x2_d, y_q, y_d, t_q, t_d;
  logic [1:0]  iter_q, iter_d;
  logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d, op_valid_q, op_valid_d;
  op_sel_t     op_sel_q, op_sel_d;
  logic [31:0] out_data_q, out_data_d, op_a_q, op_a_d, op_b_q, op_b_d;
  logic        accept_s, fire_s, special_s;
  logic [31:0] seed_s, special_val_s;

  // a done pulse only counts while a request is actually outstanding
  assign accept_s = in_valid && in_ready_q;
  assign fire_s   = op_valid_q && op_done;

  invsqrt_seed #(.MAGIC(MAGIC)) u_seed (
    .x_i          (in_data),
    .seed_o       (seed_s),
    .special_o    (special_s),
    .special_val_o(special_val_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= 32'h0;
      x2_q    <= 32'h0;
      y_q     <= 32'h0;
      t_q     <= 32'h0;
      iter_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      x2_q    <= x2_d;
      y_q     <= y_d;
      t_q     <= t_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    x2_d    = x2_q;
    y_d     = y_q;
    t_d     = t_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          x_d    = in_data;
          iter_d = 2'd0;
          if (special_s) begin
            y_d     = special_val_s;
            state_d = DONE;
          end else begin
            y_d     = seed_s;
            state_d = (NR_ITER > 0) ? HALF : DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HALF: begin
        if (fire_s) begin
          x2_d    = op_result;
          state_d = SQ;
        end else begin
          state_d = HALF;
        end
      end
      SQ: begin
        if (fire_s) begin
          t_d     = op_result;
          state_d = MULX;
        end else begin
          state_d = SQ;
        end
      end
      MULX: begin
        if (fire_s) begin
          t_d     = op_result;
          state_d = SUB;
        end else begin
          state_d = MULX;
        end
      end
      SUB: begin
        if (fire_s) begin
          t_d     = op_result;
          state_d = UPD;
        end else begin
          state_d = SUB;
        end
      end
      UPD: begin
        if (fire_s) begin
          y_d     = op_result;
          iter_d  = iter_q + 2'd1;
          state_d = ((iter_q + 2'd1) < NR_LIM) ? SQ : DONE;
        end else begin
          state_d = UPD;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // op_valid rises the cycle after entering an op state and falls on the edge that takes op_done
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    out_data_d  = (state_d == DONE) ? y_d : 32'h0;
    op_valid_d  = 1'b0;
    op_sel_d    = OP_MUL;
    op_a_d      = 32'h0;
    op_b_d      = 32'h0;
    if (is_op_state(state_q) && !fire_s) begin
      op_valid_d = 1'b1;
      case (state_q)
        HALF: begin op_a_d = x_q;  op_b_d = FP_HALF; end
        SQ:   begin op_a_d = y_q;  op_b_d = y_q;     end
        MULX: begin op_a_d = x2_q; op_b_d = t_q;     end
        SUB:  begin op_sel_d = OP_SUB; op_a_d = FP_THREEHALFS; op_b_d = t_q; end
        UPD:  begin op_a_d = y_q;  op_b_d = t_q;     end
        default: op_valid_d = 1'b0;
      endcase
    end else begin
      op_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      op_valid_q  <= 1'b0;
      op_sel_q    <= OP_MUL;
      op_a_q      <= 32'h0;
      op_b_q      <= 32'h0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      op_valid_q  <= op_valid_d;
      op_sel_q    <= op_sel_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign op_valid  = op_valid_q;
  assign op_sel    = op_sel_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;

endmodule

// File: tb/tb_invsqrt_nr_ctrl.sv
// Scoreboard bench for invsqrt_nr_ctrl: three instances with NR_ITER = 0, 1, 2 sharing one clock and reset.
module tb_invsqrt_nr_ctrl;
  import invsqrt_pkg::*;

  localparam int N_DUT = 3;
  localparam int TMO   = 2000;

  typedef struct packed {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_DUT-1:0] in_valid, in_ready, out_valid, out_ready, op_valid, op_sel, stray_done;
  logic [31:0] in_data [N_DUT];
  logic [31:0] out_data [N_DUT];
  logic [31:0] op_a [N_DUT];
  logic [31:0] op_b [N_DUT];
  logic [31:0] fp_result [N_DUT];
  logic        fp_done [N_DUT];

  logic [31:0] exp_res [N_DUT][$];
  op_t         op_q [N_DUT][$];
  logic [31:0] last_out [N_DUT];
  int          ops_seen [N_DUT];
  bit          busy [N_DUT];
  int          cnt [N_DUT];
  op_t         cur [N_DUT];
  bit          abort_flag = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    invsqrt_nr_ctrl #(.NR_ITER(g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .op_valid (op_valid[g]),
      .op_sel   (op_sel[g]),
      .op_a     (op_a[g]),
      .op_b     (op_b[g]),
      .op_done  (fp_done[g] | stray_done[g]),
      .op_result(fp_result[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait expired after %0d cycles", name, TMO);
  endtask

  // FP32 <-> real, normal numbers only, round to nearest even
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [31:0] res;
    logic [28:0] rem;
    b = $realtobits(r);
    if (b[62:0] == 63'd0) return {b[63], 31'd0};
    res = {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
    rem = b[28:0];
    if ((rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && res[0])) res = res + 32'd1;
    return res;
  endfunction

  function automatic logic [31:0] fp_exec(input op_t o);
    if (o.sel) return r2f(f2r(o.a) - f2r(o.b));
    else return r2f(f2r(o.a) * f2r(o.b));
  endfunction

  function automatic op_t mk(input logic s, input logic [31:0] a, input logic [31:0] b);
    return {s, a, b};
  endfunction

  function automatic logic [31:0] st(input int g);
    return {29'd0, out_valid[g], in_ready[g], op_valid[g]};
  endfunction

  // reference model: pushes the expected op stream and final result for instance g
  task automatic predict(input int g, input logic [31:0] x);
    logic [31:0] y, x2, t;
    op_t o;
    bit special;
    special = 1'b0;
`ifdef INVSQRT_SPECIAL_EN
    special = 1'b1;
    if (x[30:23] == 8'h00) y = 32'h7F800000;
    else if (x[30:23] == 8'hFF && x[22:0] != 23'd0) y = 32'h7FC00000;
    else if (x[31]) y = 32'h7FC00000;
    else if (x[30:23] == 8'hFF) y = 32'h00000000;
    else special = 1'b0;
`endif
    if (!special) begin
      y = MAGIC_DEF - {1'b0, x[31:1]};
      if (g > 0) begin
        o = mk(1'b0, x, FP_HALF); op_q[g].push_back(o); x2 = fp_exec(o);
        for (int i = 0; i < g; i++) begin
          o = mk(1'b0, y, y);             op_q[g].push_back(o); t = fp_exec(o);
          o = mk(1'b0, x2, t);            op_q[g].push_back(o); t = fp_exec(o);
          o = mk(1'b1, FP_THREEHALFS, t); op_q[g].push_back(o); t = fp_exec(o);
          o = mk(1'b0, y, t);             op_q[g].push_back(o); y = fp_exec(o);
        end
      end
    end
    exp_res[g].push_back(y);
  endtask

  task automatic send(input int g, input logic [31:0] x);
    int n;
    predict(g, x);
    @(negedge clk);
    in_data[g]  = x;
    in_valid[g] = 1'b1;
    n = 0;
    while (!in_ready[g] && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout($sformatf("dut%0d_accept", g));
    @(posedge clk);
    #1 in_valid[g] = 1'b0;
  endtask

  task automatic wait_drain(input int g);
    int n;
    n = 0;
    while ((exp_res[g].size() != 0 || !in_ready[g]) && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout($sformatf("dut%0d_drain", g));
  endtask

  // FP unit model: checks each request against the expected stream, answers after a latency
  initial begin
    op_t e;
    int lat;
    for (int g = 0; g < N_DUT; g++) begin
      fp_done[g] = 1'b0; fp_result[g] = 32'h0; busy[g] = 1'b0; cnt[g] = 0; ops_seen[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < N_DUT; g++) begin
        if (fp_done[g]) begin
          fp_done[g] = 1'b0;
        end else begin
          if (!busy[g] && op_valid[g]) begin
            ops_seen[g]++;
            cur[g] = {op_sel[g], op_a[g], op_b[g]};
            if (op_q[g].size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL dut%0d_unexpected_op: actual sel=%0b a=%h b=%h required no op", g, op_sel[g], op_a[g], op_b[g]);
            end else begin
              e = op_q[g].pop_front();
              chk($sformatf("dut%0d_op_sel", g), {31'd0, op_sel[g]}, {31'd0, e.sel});
              chk($sformatf("dut%0d_op_a", g), op_a[g], e.a);
              chk($sformatf("dut%0d_op_b", g), op_b[g], e.b);
            end
            lat = (g == 2) ? 1 + (ops_seen[g] % 4) : 3;
            busy[g] = 1'b1;
            cnt[g]  = lat - 1;
          end
          if (busy[g]) begin
            if (cnt[g] == 0) begin
              if (!abort_flag) begin
                chk($sformatf("dut%0d_op_hold", g), {op_valid[g], op_a[g][30:0]}, {1'b1, cur[g].a[30:0]});
                chk($sformatf("dut%0d_op_hold_b", g), op_b[g], cur[g].b);
              end
              fp_result[g] = fp_exec(cur[g]);
              fp_done[g]   = 1'b1;
              busy[g]      = 1'b0;
            end else begin
              cnt[g]--;
            end
          end
        end
      end
    end
  end

  // result monitor: pops the scoreboard on every completed output handshake
  initial begin
    logic [31:0] e;
    for (int g = 0; g < N_DUT; g++) last_out[g] = 32'h0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < N_DUT; g++) begin
        if (out_valid[g] && out_ready[g]) begin
          last_out[g] = out_data[g];
          if (exp_res[g].size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL dut%0d_unexpected_out: actual %h required no output", g, out_data[g]);
          end else begin
            e = exp_res[g].pop_front();
            chk($sformatf("dut%0d_out_data", g), out_data[g], e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    real v;
    int  n, base;
    in_valid = '0; out_ready = 3'b101; stray_done = '0;
    for (int g = 0; g < N_DUT; g++) in_data[g] = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < N_DUT; g++) begin
      chk($sformatf("dut%0d_rst_status", g), st(g), 32'h0);
      chk($sformatf("dut%0d_rst_out_data", g), out_data[g], 32'h0);
      chk($sformatf("dut%0d_rst_op_ab", g), op_a[g] | op_b[g] | {31'd0, op_sel[g]}, 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < N_DUT; g++) chk($sformatf("dut%0d_idle_ready", g), st(g), 32'h2);

    // stray op_done while idle
    stray_done[1] = 1'b1;
    @(negedge clk);
    stray_done[1] = 1'b0;
    repeat (3) begin @(negedge clk); chk("stray_idle", st(1), 32'h2); end
    chk("stray_no_ops", 32'(ops_seen[1]), 32'd0);

    // NR_ITER=0: seed only
    send(0, 32'h3F800000);
    wait_drain(0);
    chk("nr0_one", last_out[0], 32'h3F7759DF);
    chk("nr0_no_ops", 32'(ops_seen[0]), 32'd0);

    // NR_ITER=1 on 4.0 with output back-pressure
    send(1, 32'h40800000);
    n = 0;
    while (!out_valid[1] && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout("bp_out_valid");
    held = out_data[1];
    v = f2r(held);
    n_checks++;
    if (v < 0.499 || v > 0.501) begin
      n_fail++;
      $display("FAIL nr1_four_tol: actual %h required within 0.2%% of 0.5", held);
    end
    repeat (10) begin
      @(negedge clk);
      chk("bp_status", st(1), 32'h4);
      chk("bp_data", out_data[1], held);
    end
    chk("bp_ops", 32'(ops_seen[1]), 32'd5);
    @(posedge clk);
    #1 out_ready[1] = 1'b1;
    @(posedge clk);
    #1 chk("bp_release_idle", st(1), 32'h2);
    wait_drain(1);

    // reset in the middle of MULX
    base = ops_seen[1];
    send(1, 32'h40800000);
    n = 0;
    while (ops_seen[1] != base + 3 && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout("abort_reach_mulx");
    abort_flag = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_status", st(1), 32'h0);
    chk("abort_out_data", out_data[1], 32'h0);
    chk("abort_op_ab", op_a[1] | op_b[1] | {31'd0, op_sel[1]}, 32'h0);
    rst = 1'b0;
    repeat (6) begin @(negedge clk); chk("abort_quiet", st(1) & 32'h5, 32'h0); end
    chk("abort_idle", st(1), 32'h2);
    chk("abort_ops", 32'(ops_seen[1]), 32'(base + 3));
    exp_res[1].delete();
    op_q[1].delete();
    abort_flag = 1'b0;

    // recovery after abort
    send(1, 32'h40800000);
    wait_drain(1);
    chk("recover_ops", 32'(ops_seen[1]), 32'(base + 8));

`ifdef INVSQRT_SPECIAL_EN
    send(0, 32'hC0800000);
    wait_drain(0);
    chk("special_neg", last_out[0], 32'h7FC00000);
    send(0, 32'h00000000);
    wait_drain(0);
    chk("special_zero", last_out[0], 32'h7F800000);
    chk("special_no_ops", 32'(ops_seen[0]), 32'd0);
`endif

    // NR_ITER=2: back-to-back random positive normals
    for (int i = 0; i < 16; i++) begin
      send(2, {1'b0, 8'($urandom_range(100, 154)), 23'($urandom)});
    end
    wait_drain(2);
    chk("nr2_ops", 32'(ops_seen[2]), 32'd144);
    for (int g = 0; g < N_DUT; g++) chk($sformatf("dut%0d_sb_empty", g), 32'(exp_res[g].size() + op_q[g].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
